// File: rtl/lcg_stim_gen_if.sv
// Valid/ready vector channel between the LCG stimulus source and its consumer.
interface lcg_stim_gen_if #(
  parameter int unsigned OUT_W = 261
) ();
  logic [OUT_W-1:0] vec_data;
  logic             vec_valid;
  logic             vec_ready;

  modport master (output vec_data, output vec_valid, input vec_ready);
  modport slave  (input vec_data, input vec_valid, output vec_ready);
endinterface

// File: rtl/lcg_stim_gen.sv
// Stimulus source: fills OUT_W-bit vectors one 32-bit word per cycle from a 32-bit LCG
// (or a walking one) and presents them over a valid/ready handshake.
module lcg_stim_gen #(
  parameter int unsigned OUT_W = 261,
  parameter logic [31:0] SEED  = 32'hCC835209,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic [CNT_W-1:0] num_vec,
  lcg_stim_gen_if.master   vec_if,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count
);

  localparam int unsigned Nw      = (OUT_W + 31) / 32;
  localparam int unsigned IdxW    = (Nw > 1) ? $clog2(Nw) : 1;
  localparam int unsigned PosW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Nw - 1);
  localparam logic [PosW-1:0] LastPos = PosW'(OUT_W - 1);
  localparam logic [31:0] LcgMul  = 32'h41C64E6D;
  localparam logic [31:0] LcgInc  = 32'h0000_3039;

  typedef enum logic [1:0] {StIdle, StFill, StPresent} state_e;

  state_e            state_q, state_d;
  logic [31:0]       rng_q, rng_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic [IdxW-1:0]   word_idx_q, word_idx_d;
  logic [PosW-1:0]   walk_pos_q, walk_pos_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  num_vec_q, num_vec_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;

  logic [31:0]       rng_next;
  logic [CNT_W-1:0]  count_inc;

  assign rng_next  = rng_q * LcgMul + LcgInc;
  assign count_inc = count_q + CNT_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (num_vec == '0) ? StIdle : StFill;
      end
      StFill: begin
        if (word_idx_q == LastIdx) state_d = StPresent;
      end
      StPresent: begin
        if (vec_if.vec_ready) state_d = (count_inc == num_vec_q) ? StIdle : StFill;
      end
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // FSM outputs
  always_comb begin
    busy             = (state_q != StIdle);
    vec_if.vec_valid = (state_q == StPresent);
    vec_if.vec_data  = data_q;
    done             = done_q;
    vec_count        = count_q;
  end

  // Datapath next state; abort freezes everything so rng_state and vec_count keep their values.
  always_comb begin
    rng_d      = rng_q;
    data_d     = data_q;
    word_idx_d = word_idx_q;
    walk_pos_d = walk_pos_q;
    count_d    = count_q;
    num_vec_d  = num_vec_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    if (!abort) begin
      unique case (state_q)
        StIdle: begin
          if (seed_load) rng_d = seed_in;
          if (start) begin
            mode_d     = mode;
            num_vec_d  = num_vec;
            count_d    = '0;
            walk_pos_d = '0;
            word_idx_d = '0;
            done_d     = (num_vec == '0);
          end
        end
        StFill: begin
          if (!mode_q) rng_d = rng_next;
          // walk_pos_q tracks vec_count mod OUT_W, so the walking one needs no wide shifter
          for (int i = 0; i < int'(OUT_W); i++) begin
            if (word_idx_q == IdxW'(i / 32)) begin
              data_d[i] = mode_q ? (walk_pos_q == PosW'(i)) : rng_next[i % 32];
            end
          end
          word_idx_d = (word_idx_q == LastIdx) ? '0 : word_idx_q + IdxW'(1);
        end
        StPresent: begin
          if (vec_if.vec_ready) begin
            count_d    = (count_q == '1) ? count_q : count_inc;
            walk_pos_d = (walk_pos_q == LastPos) ? '0 : walk_pos_q + PosW'(1);
            done_d     = (count_inc == num_vec_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rng_q      <= SEED;
      data_q     <= '0;
      word_idx_q <= '0;
      walk_pos_q <= '0;
      count_q    <= '0;
      num_vec_q  <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rng_q      <= rng_d;
      data_q     <= data_d;
      word_idx_q <= word_idx_d;
      walk_pos_q <= walk_pos_d;
      count_q    <= count_d;
      num_vec_q  <= num_vec_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Scoreboard bench for lcg_stim_gen: an arithmetic reference model queues expected vectors,
// a negedge monitor pops and compares on every handshake.
module tb_lcg_stim_gen;

  localparam int unsigned OUT_W = 40;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned NW    = (OUT_W + 31) / 32;
  localparam logic [31:0] SEED  = 32'hCC835209;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             mode = 1'b0;
  logic             seed_load = 1'b0;
  logic [31:0]      seed_in = '0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_count;

  lcg_stim_gen_if #(.OUT_W(OUT_W)) vif ();

  lcg_stim_gen #(
    .OUT_W(OUT_W),
    .SEED (SEED),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .seed_load(seed_load),
    .seed_in  (seed_in),
    .num_vec  (num_vec),
    .vec_if   (vif.master),
    .busy     (busy),
    .done     (done),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model
  logic [31:0]      m_rng;
  logic [OUT_W-1:0] exp_q[$];

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h0000_3039;
  endfunction

  task automatic model_run(input int n, input bit md);
    logic [NW*32-1:0] w;
    for (int v = 0; v < n; v++) begin
      if (md) begin
        exp_q.push_back(OUT_W'(1) << (v % OUT_W));
      end else begin
        for (int k = 0; k < int'(NW); k++) begin
          m_rng = lcg(m_rng);
          w[k*32 +: 32] = m_rng;
        end
        exp_q.push_back(w[OUT_W-1:0]);
      end
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = stalled
  int ready_mode = 0;
  initial begin
    vif.vec_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       vif.vec_ready = 1'b1;
        1:       vif.vec_ready = 1'($urandom_range(0, 1));
        default: vif.vec_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  logic [OUT_W-1:0] held_data;
  logic [OUT_W-1:0] last_vec = '0;
  bit               held = 1'b0;
  bit               prev_done = 1'b0;
  int               done_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held      = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          chk("done_single_cycle", prev_done, 1'b0);
        end
        prev_done = done;
        if (vif.vec_valid) begin
          if (held) chk("hold_data", vif.vec_data, held_data);
          if (vif.vec_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_vector: got %0h required none", vif.vec_data);
            end else begin
              chk("vector", vif.vec_data, exp_q.pop_front());
            end
            last_vec = vif.vec_data;
            held     = 1'b0;
          end else begin
            held      = 1'b1;
            held_data = vif.vec_data;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic start_run(input int n, input bit md, input bit sl, input logic [31:0] sd);
    @(posedge clk);
    #1;
    start     = 1'b1;
    mode      = md;
    num_vec   = CNT_W'(n);
    seed_load = sl;
    seed_in   = sd;
    if (sl) m_rng = sd;
    model_run(n, md);
    @(posedge clk);
    #1;
    start     = 1'b0;
    seed_load = 1'b0;
    mode      = 1'($urandom_range(0, 1));
    num_vec   = CNT_W'($urandom);
    seed_in   = $urandom;
  endtask

  task automatic finish_run(input int n, input bit chk_timing);
    int first_valid = 0;
    int cyc = 0;
    bit got = 1'b0;
    for (int c = 1; c <= n * int'(NW + 1) * 8 + 100; c++) begin
      @(negedge clk);
      if (vif.vec_valid && first_valid == 0) first_valid = c;
      if (done) begin
        got = 1'b1;
        cyc = c;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL run_timeout: no done, vec_count=%0d required %0d", vec_count, n);
      exp_q.delete();
    end else begin
      chk("vec_count", vec_count, 64'(n));
      chk("queue_drained", 64'(exp_q.size()), 0);
      if (n == 0) chk("no_valid_on_zero", 64'(first_valid), 0);
      if (chk_timing) begin
        if (n > 0) chk("first_valid_latency", 64'(first_valid), 64'(NW + 1));
        chk("done_cycle", 64'(cyc), 64'(n * int'(NW + 1) + 1));
      end
    end
  endtask

  task automatic wait_valid(input string name);
    bit got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (vif.vec_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, got, 1'b1);
  endtask

  initial begin
    logic [31:0] rng_before;
    bit          reached;
    int          done_before;

    m_rng = SEED;
    repeat (3) @(negedge clk);
    chk("rst_valid", vif.vec_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", vec_count, 0);
    chk("rst_data", vif.vec_data, 0);
    #2 rst_n = 1'b1;

    // Long LCG run from the reset seed, ready held high: checks spacing and done timing
    ready_mode = 0;
    start_run(30, 1'b0, 1'b0, 32'h0);
    finish_run(30, 1'b1);

    // Seed 0, one vector: first word 0x3039, second word's low byte 0x7E
    start_run(1, 1'b0, 1'b1, 32'h0);
    finish_run(1, 1'b1);
    chk("known_vector", last_vec, 40'h7E_0000_3039);

    // Backpressure: stall 20 cycles in PRESENT
    ready_mode = 2;
    start_run(3, 1'b0, 1'b0, 32'h0);
    wait_valid("bp_valid_seen");
    repeat (20) begin
      @(negedge clk);
      chk("bp_valid_held", vif.vec_valid, 1'b1);
      chk("bp_count_held", vec_count, 0);
    end
    ready_mode = 1;
    finish_run(3, 1'b0);

    // Walking one past the OUT_W wrap, then LCG continues from an untouched rng
    ready_mode = 0;
    start_run(45, 1'b1, 1'b0, 32'h0);
    finish_run(45, 1'b1);
    ready_mode = 1;
    start_run(3, 1'b0, 1'b0, 32'h0);
    finish_run(3, 1'b0);

    // start / seed_load / mode / num_vec while busy must be ignored
    ready_mode = 0;
    start_run(4, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    start = 1'b1; seed_load = 1'b1; seed_in = 32'hDEAD_BEEF; mode = 1'b1; num_vec = 9;
    @(posedge clk);
    #1;
    start = 1'b0; seed_load = 1'b0;
    finish_run(4, 1'b0);

    // Abort after word 0 of vector 3
    rng_before  = m_rng;
    done_before = done_cnt;
    start_run(5, 1'b0, 1'b0, 32'h0);
    reached = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (vec_count == 3) begin
        reached = 1'b1;
        break;
      end
    end
    chk("abort_reach_count3", reached, 1'b1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 1'b0);
    chk("abort_valid", vif.vec_valid, 1'b0);
    chk("abort_count", vec_count, 3);
    repeat (2) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(done_before));
    exp_q.delete();
    m_rng = rng_before;
    repeat (3 * NW + 1) m_rng = lcg(m_rng);
    start_run(2, 1'b0, 1'b0, 32'h0);
    finish_run(2, 1'b1);

    // num_vec = 0
    start_run(0, 1'b0, 1'b0, 32'h0);
    finish_run(0, 1'b1);

    // Randomised runs
    ready_mode = 1;
    for (int r = 0; r < 8; r++) begin
      int          n;
      bit          md;
      bit          sl;
      logic [31:0] sd;
      n  = $urandom_range(1, 12);
      md = 1'($urandom_range(0, 1));
      sl = 1'($urandom_range(0, 1));
      sd = $urandom;
      start_run(n, md, sl, sd);
      finish_run(n, 1'b0);
    end

    // Reset while presenting
    ready_mode = 2;
    start_run(3, 1'b0, 1'b1, 32'h1234_5678);
    wait_valid("prst_valid_seen");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("prst_valid", vif.vec_valid, 1'b0);
    chk("prst_busy", busy, 1'b0);
    chk("prst_count", vec_count, 0);
    exp_q.delete();
    m_rng = SEED;
    @(negedge clk);
    #2 rst_n = 1'b1;
    ready_mode = 0;
    start_run(2, 1'b0, 1'b0, 32'h0);
    finish_run(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcg_stim_gen.md
Name: lcg_stim_gen

Overview:
Synthesizable, parametrised stimulus source for the fuzz-harness top level. It generates OUT_W-bit test vectors with the 32-bit LCG the benches already use (state = state*0x41C64E6D + 0x3039 mod 2^32). Vectors are delivered over a valid/ready handshake, one 32-bit word per fill cycle. It adds a vector-count limit, runtime seed load, a walking-one mode, abort and done signalling, so DUT wrappers can be driven on-chip or in lint-clean simulation.

Parameters:
OUT_W, 261, vector width in bits (>=1); NW = ceil(OUT_W/32) words per vector
SEED, 32'hCC835209, rng_state value after reset (decimal 3431158281)
CNT_W, 32, width of vector counter and num_vec

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled in IDLE only
abort  input  1  synchronous abort to IDLE, any state
mode  input  1  0 = LCG, 1 = walking-one; latched at start
seed_load  input  1  load seed_in into rng_state; honoured in IDLE only
seed_in  input  32  seed value
num_vec  input  CNT_W  vectors per run; latched at start
vec_data  output  OUT_W  current vector
vec_valid  output  1  vec_data complete and stable
vec_ready  input  1  consumer accepts vector
busy  output  1  high in FILL or PRESENT
done  output  1  one-cycle pulse at run completion
vec_count  output  CNT_W  vectors accepted in current or last run

Behaviour:
- Reset (async assert, sync release): rng_state=SEED, vec_data=0, vec_valid=0, busy=0, done=0, vec_count=0, FSM=IDLE, word index=0.
- States: IDLE, FILL, PRESENT.
- IDLE: seed_load=1 sets rng_state=seed_in. If start=1 and seed_load=1 in the same cycle, seed load takes effect first; the first word uses the new seed.
- IDLE, start=1: latch mode and num_vec; clear vec_count.
  - num_vec=0: pulse done next cycle, stay IDLE.
  - Otherwise: go to FILL with word index 0.
- FILL: one word per cycle, word k (k=0..NW-1) written to vec_data[32k+31:32k]. The top word is truncated to its low OUT_W-32(NW-1) bits.
  - LCG mode: rng_state advances, and the word is the new state.
  - Walk mode: rng_state is not advanced. Word k is the slice of (1 << (vec_count mod OUT_W)).
  - After word NW-1 is written, go to PRESENT and set vec_valid=1.
- Latency: start edge E0, words written at edges E1..ENW, vec_valid=1 after edge ENW.
- PRESENT: vec_valid=1; vec_data is held stable while vec_ready=0, with no timeout.
- Handshake: on an edge with vec_valid&vec_ready, vec_count increments and vec_valid drops.
  - If the new vec_count equals the latched num_vec: go to IDLE with done=1 for one cycle.
  - Otherwise: go to FILL.
- Throughput: one vector per NW+1 cycles when ready is held high.
- start, seed_load, mode and num_vec changes while busy are ignored.
- abort: takes priority over everything except reset. Next state IDLE, vec_valid=0, done not pulsed. vec_count keeps its partial value; rng_state keeps its current value.
- vec_count saturates at CNT_W width (num_vec bounds it).
- vec_data is not cleared between vectors; it is only meaningful while vec_valid=1.
- Asserting reset mid-run returns all state to reset values immediately.

Test Plan:
- OUT_W=40 (NW=2), seed_load with seed_in=0, start with num_vec=1, vec_ready=1. Required: vec_valid high after 3 edges with vec_data=40'h7E_0000_3039; done pulse one cycle after the handshake; vec_count=1.
- Default params, no seed load, num_vec=300, ready=1. Required: 300 vectors at 10-cycle spacing; vec_data[31:0] of vector 0 = SEED*0x41C64E6D+0x3039; done once; vec_count=300.
- Backpressure: hold vec_ready=0 for 20 cycles in PRESENT. Required: vec_data and vec_valid stable; no rng advance; count unchanged until ready rises.
- Walk mode, OUT_W=8, num_vec=10. Required: vector sequence 0x01,0x02,...,0x80,0x01,0x02; rng_state unchanged afterwards.
- Abort in FILL after word 0 of vector 3. Required: IDLE next cycle, vec_valid=0, done never pulses, vec_count=3; a fresh start resumes from the current rng_state.
- Edge cases:
  - num_vec=0 gives a done pulse with no valid.
  - start while busy is ignored.
  - rst_n low mid-PRESENT clears vec_valid asynchronously and restores rng_state=SEED.
